lsq_srb_buf: RTL and testbench
==============================

// Module: lsq_srb_buf
// PURPOSE
// - Entry storage and allocation control for the LSQ sparse read buffer (SRB).
// - Allocates entries in order at an internal write pointer. Releases entries out of order by index.
// - Exports the per-entry valid vector consumed by the bottom-pointer generator (bottom_ptr comes back in).
// - Provides a registered read-data response to the issue stage.
// PARAMETERS
// - SRB_DEPTH  8   number of entries; power of two, >= 2
// - DATA_W     32  payload width per entry
// - PTR_W = $clog2(SRB_DEPTH) (localparam); CNT_W = PTR_W+1 (localparam)
// PORTS
// clk          in   1          clock
// rst          in   1          synchronous reset, active-high
// w_req_valid  in   1          allocate request
// w_req_ready  out  1          allocation possible this cycle
// w_data       in   DATA_W     payload written on allocation
// w_alloc_ptr  out  PTR_W      index allocated when valid&ready (current w_ptr)
// r_req_valid  in   1          release/read request
// r_req_ptr    in   PTR_W      index to read and release
// r_rsp_valid  out  1          read response valid (1-cycle latency)
// r_rsp_data   out  DATA_W     payload of released entry
// entry_valid  out  SRB_DEPTH  per-entry occupied flags (to bottom-pointer generator)
// bottom_ptr   in   PTR_W      oldest occupied index (from bottom-pointer generator)
// occupancy    out  CNT_W      number of occupied entries, 0..SRB_DEPTH
// empty        out  1          occupancy == 0
// err_rel      out  1          sticky: release of an unoccupied entry (SRB_ERR_CHK_EN only)
// BEHAVIOUR
// - Reset: w_ptr=0; entry_valid=0; occupancy=0; r_rsp_valid=0; r_rsp_data=0; err_rel=0; empty=1.
// - w_req_ready = ~entry_valid[w_ptr] (combinational, current state only, no same-cycle release bypass).
// - Allocation (w_req_valid & w_req_ready): mem[w_ptr]<=w_data; entry_valid[w_ptr]<=1; w_ptr<=w_ptr+1 modulo SRB_DEPTH.
// - w_alloc_ptr = w_ptr at all times.
// - Release is accepted iff r_req_valid & entry_valid[r_req_ptr]. On accept:
//   - entry_valid[r_req_ptr]<=0.
//   - Next cycle r_rsp_valid=1 and r_rsp_data=mem[r_req_ptr].
// - A non-accepted release sets r_rsp_valid=0 next cycle; r_rsp_data holds its last value.
// - No backpressure on the response.
// - Simultaneous allocate and release, different indices: both take effect; occupancy unchanged.
// - Allocate and release aimed at the same index in the same cycle:
//   - Release sees the pre-write state (entry unoccupied), so it is not accepted.
//   - The allocation still completes.
// - Holes: w_ptr stalls on an occupied slot even if other slots are free. Full condition = entry_valid[w_ptr].
// - Occupancy: +1 on allocate, -1 on accepted release, net 0 on both. Never wraps.
//   - Invariant: occupancy == popcount(entry_valid).
// - bottom_ptr is used only for the debug invariant: when not empty, entry_valid[bottom_ptr]==1.
//   - Checked by an assertion; no functional effect.
// - Reset mid-operation: all state returns to reset values in the same edge. In-flight response is dropped.
// - Memory contents are not reset. Only entry_valid qualifies them.
// CONFIGURATION
// - SRB_ERR_CHK_EN defined:
//   - A release with r_req_valid=1 to an unoccupied index sets err_rel=1 next cycle.
//   - err_rel stays 1 until reset.
//   - Assertion on the bottom_ptr invariant is compiled in.
// - SRB_ERR_CHK_EN undefined: err_rel tied 0; such releases are silently ignored; no assertion.
// TESTING
// - Reset, then 8 allocs w_data=0xA0..0xA7:
//   - w_alloc_ptr 0..7; entry_valid=0xFF; occupancy=8; w_req_ready=0.
// - From full, release ptr 3:
//   - Next cycle r_rsp_valid=1, r_rsp_data=0xA3; entry_valid=0xF7.
//   - w_req_ready stays 0 (w_ptr=0 still occupied).
// - Release 0, then alloc 0xB0:
//   - Allocated at index 0; w_ptr=1; occupancy=7; entry_valid=0xF7.
// - Same cycle: alloc at w_ptr=k (free) and release ptr j (occupied, j!=k):
//   - Both occur; occupancy unchanged; rsp next cycle with mem[j].
// - Release an unoccupied index 5:
//   - r_rsp_valid=0; state unchanged.
//   - err_rel=1 with SRB_ERR_CHK_EN defined, 0 without.
// - Assert rst with 4 occupied and a release accepted the same cycle:
//   - Next cycle entry_valid=0, occupancy=0, r_rsp_valid=0, w_alloc_ptr=0, empty=1.

Source files
------------

// File: rtl/lsq_srb_buf.sv
// lsq_srb_buf: entry storage for the LSQ sparse read buffer; allocates in order, releases out of order by index.
// Optional macro SRB_ERR_CHK_EN: sticky err_rel on release of an unoccupied entry, plus the bottom_ptr invariant assertion.
module lsq_srb_buf #(
    parameter int SRB_DEPTH = 8,
    parameter int DATA_W    = 32,
    localparam int PTR_W    = $clog2(SRB_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_req_valid,
    output logic                 w_req_ready,
    input  logic [DATA_W-1:0]    w_data,
    output logic [PTR_W-1:0]     w_alloc_ptr,
    input  logic                 r_req_valid,
    input  logic [PTR_W-1:0]     r_req_ptr,
    output logic                 r_rsp_valid,
    output logic [DATA_W-1:0]    r_rsp_data,
    output logic [SRB_DEPTH-1:0] entry_valid,
    input  logic [PTR_W-1:0]     bottom_ptr,
    output logic [CNT_W-1:0]     occupancy,
    output logic                 empty,
    output logic                 err_rel
);

    logic [PTR_W-1:0]     w_ptr;
    logic [DATA_W-1:0]    mem [SRB_DEPTH];
    logic [SRB_DEPTH-1:0] entry_valid_next;
    logic                 alloc;
    logic                 rel_ok;

    // A release and allocation aimed at the same index can never both be accepted:
    // the allocation needs the slot free, the release needs it occupied.
    assign w_req_ready = ~entry_valid[w_ptr];
    assign alloc       = w_req_valid & w_req_ready;
    assign rel_ok      = r_req_valid & entry_valid[r_req_ptr];
    assign w_alloc_ptr = w_ptr;
    assign empty       = (occupancy == '0);

    always_comb begin
        entry_valid_next = entry_valid;
        if (alloc) begin
            entry_valid_next[w_ptr] = 1'b1;
        end
        if (rel_ok) begin
            entry_valid_next[r_req_ptr] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr       <= '0;
            entry_valid <= '0;
            occupancy   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            entry_valid <= entry_valid_next;
            r_rsp_valid <= rel_ok;
            if (alloc) begin
                w_ptr <= w_ptr + PTR_W'(1);
            end
            if (rel_ok) begin
                r_rsp_data <= mem[r_req_ptr];
            end
            unique case ({alloc, rel_ok})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Payload storage is never reset; entry_valid alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (alloc && !rst) begin
            mem[w_ptr] <= w_data;
        end
    end

`ifdef SRB_ERR_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_rel <= 1'b0;
        end else if (r_req_valid && !entry_valid[r_req_ptr]) begin
            err_rel <= 1'b1;
        end
    end

    bottom_ptr_occupied: assert property (@(posedge clk) disable iff (rst)
        !empty |-> entry_valid[bottom_ptr]);
`else
    logic unused_bottom_ptr;

    assign err_rel           = 1'b0;
    assign unused_bottom_ptr = ^bottom_ptr;
`endif

endmodule

// File: tb/tb_lsq_srb_buf.sv
// tb_lsq_srb_buf: directed scenarios plus randomized traffic checked against a queue/array reference model.
// Build with +define+SRB_ERR_CHK_EN to exercise the sticky error flag.
module tb_lsq_srb_buf;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
`ifdef SRB_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          w_req_valid;
    logic          w_req_ready;
    logic [DW-1:0] w_data;
    logic [2:0]    w_alloc_ptr;
    logic          r_req_valid;
    logic [2:0]    r_req_ptr;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic [7:0]    entry_valid;
    logic [2:0]    bottom_ptr;
    logic [3:0]    occupancy;
    logic          empty;
    logic          err_rel;

    int total = 0;
    int bad   = 0;

    // Reference model: occupancy flags, payloads, allocation order of live entries.
    bit            m_valid [DEPTH];
    logic [DW-1:0] m_mem   [DEPTH];
    int            m_wptr;
    bit            m_rsp_v;
    logic [DW-1:0] m_rsp_d;
    bit            m_err;
    int            m_order [$];

    lsq_srb_buf #(.SRB_DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_data(w_data),
        .w_alloc_ptr(w_alloc_ptr),
        .r_req_valid(r_req_valid), .r_req_ptr(r_req_ptr),
        .r_rsp_valid(r_rsp_valid), .r_rsp_data(r_rsp_data),
        .entry_valid(entry_valid), .bottom_ptr(bottom_ptr),
        .occupancy(occupancy), .empty(empty), .err_rel(err_rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_ev();
        logic [7:0] v = '0;
        for (int i = 0; i < DEPTH; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic int model_occ();
        return $countones(model_ev());
    endfunction

    // One clock: apply inputs, advance the model from its pre-edge state, settle 1 time unit past the edge.
    task automatic do_cycle(input bit wv, input logic [DW-1:0] wd, input bit rv, input int rp, input bit rs);
        bit acc_alloc;
        bit acc_rel;
        w_req_valid = wv;
        w_data      = wd;
        r_req_valid = rv;
        r_req_ptr   = rp[2:0];
        rst         = rs;
        acc_alloc   = wv && !m_valid[m_wptr];
        acc_rel     = rv && m_valid[rp];
        @(posedge clk);
        #1;
        if (rs) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_wptr  = 0;
            m_rsp_v = 1'b0;
            m_rsp_d = '0;
            m_err   = 1'b0;
            m_order.delete();
        end else begin
            if (rv && !m_valid[rp] && ERR_EN) m_err = 1'b1;
            m_rsp_v = acc_rel;
            if (acc_rel) m_rsp_d = m_mem[rp];
            if (acc_alloc) begin
                m_mem[m_wptr]   = wd;
                m_valid[m_wptr] = 1'b1;
                m_order.push_back(m_wptr);
                m_wptr = (m_wptr + 1) % DEPTH;
            end
            if (acc_rel) begin
                m_valid[rp] = 1'b0;
                for (int i = 0; i < m_order.size(); i++) begin
                    if (m_order[i] == rp) begin
                        m_order.delete(i);
                        break;
                    end
                end
            end
        end
        w_req_valid = 1'b0;
        r_req_valid = 1'b0;
        rst         = 1'b0;
        bottom_ptr  = (m_order.size() > 0) ? 3'(m_order[0]) : 3'd0;
    endtask

    task automatic test_reset();
        do_cycle(0, '0, 0, 0, 1);
        total += 8;
        if (entry_valid !== 8'h00) begin bad++; $display("[TB] FAIL reset_ev got=%h want=00", entry_valid); end
        if (occupancy !== 4'd0) begin bad++; $display("[TB] FAIL reset_occ got=%0d want=0", occupancy); end
        if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", empty); end
        if (r_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rspv got=%b want=0", r_rsp_valid); end
        if (r_rsp_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_rspd got=%h want=0", r_rsp_data); end
        if (w_alloc_ptr !== 3'd0) begin bad++; $display("[TB] FAIL reset_wptr got=%0d want=0", w_alloc_ptr); end
        if (w_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", w_req_ready); end
        if (err_rel !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", err_rel); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (w_alloc_ptr !== 3'(i)) begin bad++; $display("[TB] FAIL fill_ptr got=%0d want=%0d", w_alloc_ptr, i); end
            do_cycle(1, 32'hA0 + 32'(i), 0, 0, 0);
        end
        total += 4;
        if (entry_valid !== 8'hFF) begin bad++; $display("[TB] FAIL fill_ev got=%h want=FF", entry_valid); end
        if (occupancy !== 4'd8) begin bad++; $display("[TB] FAIL fill_occ got=%0d want=8", occupancy); end
        if (w_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_ready got=%b want=0", w_req_ready); end
        if (empty !== 1'b0) begin bad++; $display("[TB] FAIL fill_empty got=%b want=0", empty); end
    endtask

    task automatic test_release_from_full();
        do_cycle(0, '0, 1, 3, 0);
        total += 5;
        if (r_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL rel3_rspv got=%b want=1", r_rsp_valid); end
        if (r_rsp_data !== 32'hA3) begin bad++; $display("[TB] FAIL rel3_rspd got=%h want=A3", r_rsp_data); end
        if (entry_valid !== 8'hF7) begin bad++; $display("[TB] FAIL rel3_ev got=%h want=F7", entry_valid); end
        if (w_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rel3_ready got=%b want=0", w_req_ready); end
        if (occupancy !== 4'd7) begin bad++; $display("[TB] FAIL rel3_occ got=%0d want=7", occupancy); end
    endtask

    task automatic test_release_then_alloc();
        do_cycle(0, '0, 1, 0, 0);
        total += 3;
        if (r_rsp_data !== 32'hA0) begin bad++; $display("[TB] FAIL rel0_rspd got=%h want=A0", r_rsp_data); end
        if (w_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rel0_ready got=%b want=1", w_req_ready); end
        if (w_alloc_ptr !== 3'd0) begin bad++; $display("[TB] FAIL rel0_ptr got=%0d want=0", w_alloc_ptr); end
        do_cycle(1, 32'hB0, 0, 0, 0);
        total += 4;
        if (w_alloc_ptr !== 3'd1) begin bad++; $display("[TB] FAIL allocB0_ptr got=%0d want=1", w_alloc_ptr); end
        if (occupancy !== 4'd7) begin bad++; $display("[TB] FAIL allocB0_occ got=%0d want=7", occupancy); end
        if (entry_valid !== 8'hF7) begin bad++; $display("[TB] FAIL allocB0_ev got=%h want=F7", entry_valid); end
        if (r_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL allocB0_rspv got=%b want=0", r_rsp_valid); end
    endtask

    task automatic test_simultaneous();
        do_cycle(0, '0, 1, 1, 0);
        do_cycle(1, 32'hC1, 1, 5, 0);
        total += 5;
        if (occupancy !== 4'd6) begin bad++; $display("[TB] FAIL simul_occ got=%0d want=6", occupancy); end
        if (r_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL simul_rspv got=%b want=1", r_rsp_valid); end
        if (r_rsp_data !== 32'hA5) begin bad++; $display("[TB] FAIL simul_rspd got=%h want=A5", r_rsp_data); end
        if (entry_valid !== 8'hD7) begin bad++; $display("[TB] FAIL simul_ev got=%h want=D7", entry_valid); end
        if (w_alloc_ptr !== 3'd2) begin bad++; $display("[TB] FAIL simul_ptr got=%0d want=2", w_alloc_ptr); end
    endtask

    task automatic test_release_unoccupied();
        do_cycle(0, '0, 1, 5, 0);
        total += 5;
        if (r_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL unocc_rspv got=%b want=0", r_rsp_valid); end
        if (r_rsp_data !== 32'hA5) begin bad++; $display("[TB] FAIL unocc_rspd got=%h want=A5", r_rsp_data); end
        if (entry_valid !== 8'hD7) begin bad++; $display("[TB] FAIL unocc_ev got=%h want=D7", entry_valid); end
        if (occupancy !== 4'd6) begin bad++; $display("[TB] FAIL unocc_occ got=%0d want=6", occupancy); end
        if (err_rel !== ERR_EN) begin bad++; $display("[TB] FAIL unocc_err got=%b want=%b", err_rel, ERR_EN); end
    endtask

    task automatic test_same_index();
        do_cycle(0, '0, 1, 2, 0);
        do_cycle(1, 32'hE2, 1, 2, 0);
        total += 5;
        if (r_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL same_rspv got=%b want=0", r_rsp_valid); end
        if (r_rsp_data !== 32'hA2) begin bad++; $display("[TB] FAIL same_rspd got=%h want=A2", r_rsp_data); end
        if (entry_valid !== 8'hD7) begin bad++; $display("[TB] FAIL same_ev got=%h want=D7", entry_valid); end
        if (w_alloc_ptr !== 3'd3) begin bad++; $display("[TB] FAIL same_ptr got=%0d want=3", w_alloc_ptr); end
        if (err_rel !== ERR_EN) begin bad++; $display("[TB] FAIL same_err got=%b want=%b", err_rel, ERR_EN); end
        do_cycle(0, '0, 1, 2, 0);
        total++;
        if (r_rsp_data !== 32'hE2) begin bad++; $display("[TB] FAIL same_rd_back got=%h want=E2", r_rsp_data); end
    endtask

    task automatic test_reset_midop();
        do_cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) do_cycle(1, 32'h50 + 32'(i), 0, 0, 0);
        total++;
        if (entry_valid !== 8'h0F) begin bad++; $display("[TB] FAIL mid_pre_ev got=%h want=0F", entry_valid); end
        do_cycle(0, '0, 1, 1, 1);
        total += 5;
        if (entry_valid !== 8'h00) begin bad++; $display("[TB] FAIL mid_ev got=%h want=00", entry_valid); end
        if (occupancy !== 4'd0) begin bad++; $display("[TB] FAIL mid_occ got=%0d want=0", occupancy); end
        if (r_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rspv got=%b want=0", r_rsp_valid); end
        if (w_alloc_ptr !== 3'd0) begin bad++; $display("[TB] FAIL mid_ptr got=%0d want=0", w_alloc_ptr); end
        if (empty !== 1'b1) begin bad++; $display("[TB] FAIL mid_empty got=%b want=1", empty); end
    endtask

    task automatic test_random();
        bit            wv;
        bit            rv;
        int            rp;
        logic [DW-1:0] wd;
        for (int n = 0; n < 400; n++) begin
            wv = ($urandom_range(0, 99) < 55);
            rv = ($urandom_range(0, 99) < 60);
            wd = $urandom;
            if (m_order.size() > 0 && $urandom_range(0, 99) < 75)
                rp = m_order[$urandom_range(0, m_order.size() - 1)];
            else
                rp = $urandom_range(0, DEPTH - 1);
            do_cycle(wv, wd, rv, rp, 0);
            total += 8;
            if (entry_valid !== model_ev()) begin bad++; $display("[TB] FAIL rnd_ev n=%0d got=%h want=%h", n, entry_valid, model_ev()); end
            if (occupancy !== 4'(model_occ())) begin bad++; $display("[TB] FAIL rnd_occ n=%0d got=%0d want=%0d", n, occupancy, model_occ()); end
            if (empty !== (model_occ() == 0)) begin bad++; $display("[TB] FAIL rnd_empty n=%0d got=%b want=%b", n, empty, model_occ() == 0); end
            if (w_alloc_ptr !== 3'(m_wptr)) begin bad++; $display("[TB] FAIL rnd_ptr n=%0d got=%0d want=%0d", n, w_alloc_ptr, m_wptr); end
            if (w_req_ready !== !m_valid[m_wptr]) begin bad++; $display("[TB] FAIL rnd_ready n=%0d got=%b want=%b", n, w_req_ready, !m_valid[m_wptr]); end
            if (r_rsp_valid !== m_rsp_v) begin bad++; $display("[TB] FAIL rnd_rspv n=%0d got=%b want=%b", n, r_rsp_valid, m_rsp_v); end
            if (r_rsp_data !== m_rsp_d) begin bad++; $display("[TB] FAIL rnd_rspd n=%0d got=%h want=%h", n, r_rsp_data, m_rsp_d); end
            if (err_rel !== m_err) begin bad++; $display("[TB] FAIL rnd_err n=%0d got=%b want=%b", n, err_rel, m_err); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        w_req_valid = 1'b0;
        w_data      = '0;
        r_req_valid = 1'b0;
        r_req_ptr   = '0;
        bottom_ptr  = '0;
        test_reset();
        test_fill();
        test_release_from_full();
        test_release_then_alloc();
        test_simultaneous();
        test_release_unoccupied();
        test_same_index();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
